// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared types and timing constants for the VGA scan
// sequencer. phase_t names the four per-axis phases; the default constants
// give standard 640x480@60 timing from a 100 MHz clock with a /4 divider.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FP     = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BP     = 2'd3
  } phase_t;

  localparam int CNT_W = 10;

  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int axis_total(input int a, input int f, input int s, input int b);
    return a + f + s + b;
  endfunction

  // first count of the sync pulse
  function automatic int sync_start(input int a, input int f);
    return a + f;
  endfunction

  // last count of the sync pulse (inclusive)
  function automatic int sync_end(input int a, input int f, input int s);
    return a + f + s - 1;
  endfunction

endpackage

// File: rtl/vga_axis_seq.sv
// vga_axis_seq: one scan axis. Counts 0..TOTAL-1 on step, walks the
// ACTIVE/FP/SYNC/BP phase FSM and exposes registered sync/active flags.
//   clk, rst_n : clock, synchronous active-low reset
//   step       : advance the axis by one position
//   count      : current position
//   wrap       : combinational, high when this step takes count LAST->0
//   sync_n     : low while the axis is in its sync phase
//   active     : high while the axis is in its visible phase
module vga_axis_seq
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             sync_n,
  output logic             active
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] FP_AT   = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_AT = CNT_W'(sync_start(ACTIVE, FP));
  localparam logic [CNT_W-1:0] BP_AT   = CNT_W'(sync_end(ACTIVE, FP, SYNC) + 1);

  logic [CNT_W-1:0] count_nxt;
  phase_t           state_q, state_nxt;

  assign wrap = step & (count == LAST);

  always_comb begin
    count_nxt = count;
    if (step) count_nxt = (count == LAST) ? '0 : count + 1'b1;
  end

  // Transitions look at the next count so the registered flags line up
  // with the count they are presented alongside.
  always_comb begin
    state_nxt = state_q;
    if (step) begin
      case (state_q)
        PH_ACTIVE: if (count_nxt == FP_AT)   state_nxt = PH_FP;
        PH_FP:     if (count_nxt == SYNC_AT) state_nxt = PH_SYNC;
        PH_SYNC:   if (count_nxt == BP_AT)   state_nxt = PH_BP;
        PH_BP:     if (count_nxt == '0)      state_nxt = PH_ACTIVE;
        default:                             state_nxt = PH_ACTIVE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count   <= '0;
      state_q <= PH_ACTIVE;
      sync_n  <= 1'b1;
      active  <= 1'b1;
    end else begin
      count   <= count_nxt;
      state_q <= state_nxt;
      sync_n  <= (state_nxt != PH_SYNC);
      active  <= (state_nxt == PH_ACTIVE);
    end
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: VGA scan timing. Divides clk down to the pixel rate,
// drives the horizontal axis on each pixel tick and the vertical axis on
// each horizontal wrap, and produces sync/blanking and line/frame strobes.
//   clk, rst_n       : system clock, synchronous active-low reset
//   enable           : run; low freezes all state and gates pix_tick
//   pix_tick         : one-clk pulse per pixel period
//   h_count, v_count : scan position
//   hsync, vsync     : active-low syncs, aligned with h_count/v_count
//   video_on         : visible region
//   line_end         : one clk, in the cycle h_count shows the wrap to 0
//   frame_start      : one clk, in the cycle the counts show (0,0) after a wrap
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  output logic       pix_tick,
  output logic [9:0] h_count,
  output logic [9:0] v_count,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       line_end,
  output logic       frame_start
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_ctrl: H_TOTAL/V_TOTAL must fit 10-bit counters");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_ctrl: CLK_DIV must be >= 1");
  end

  // keep at least one bit so CLK_DIV=1 still elaborates
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             enable_v, v_wrap;
  logic             h_act, v_act;

  always_ff @(posedge clk) begin
    if (!rst_n)      div_cnt <= '0;
    else if (enable) div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
  end

  assign pix_tick = enable & (div_cnt == DIV_LAST);

  vga_axis_seq #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h (
    .clk(clk), .rst_n(rst_n), .step(pix_tick),
    .count(h_count), .wrap(enable_v), .sync_n(hsync), .active(h_act)
  );

  vga_axis_seq #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v (
    .clk(clk), .rst_n(rst_n), .step(enable_v),
    .count(v_count), .wrap(v_wrap), .sync_n(vsync), .active(v_act)
  );

  assign video_on = h_act & v_act;

  // Strobes follow the wrap of the edge just taken; with enable low no
  // wrap can happen, so they fall back to 0 on their own.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      line_end    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_end    <= enable_v;
      frame_start <= v_wrap;
    end
  end

endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
Sequences the VGA horizontal and vertical scan counters from the 100 MHz system clock. It generates the pixel-rate tick, advances the horizontal counter, and fires the vertical enable on horizontal wrap. It decodes per-axis phase FSMs (ACTIVE/FP/SYNC/BP) into hsync, vsync, video_on and the frame/line strobes. It sits between the clock/reset and the pixel generator, and is the sole owner of scan timing.

Parameters:
CLK_DIV, 4, system clocks per pixel (≥1); 100 MHz → 25 MHz
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels); H_TOTAL = sum = 800
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines); V_TOTAL = 525

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
enable  in  1  run; low freezes divider, counters, FSMs and outputs
pix_tick  out  1  one-clk pulse per pixel period
h_count  out  10  horizontal position 0..H_TOTAL-1
v_count  out  10  vertical position 0..V_TOTAL-1
hsync  out  1  active-low horizontal sync
vsync  out  1  active-low vertical sync
video_on  out  1  high when both axes are in ACTIVE
line_end  out  1  one-clk pulse on the tick where h_count wraps
frame_start  out  1  one-clk pulse when counts become (0,0)

Behaviour:
- Sampling: all state updates on posedge clk; rst_n sampled only at the edge.
- Reset values:
  - div_cnt=0, h_count=0, v_count=0
  - h_state=ACTIVE, v_state=ACTIVE
  - hsync=1, vsync=1, video_on=1
  - line_end=0, frame_start=0
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps. pix_tick = enable & (div_cnt==CLK_DIV-1), decoded from registered state. CLK_DIV=1 gives pix_tick=enable every cycle.
- Horizontal counter:
  - Advances on pix_tick: h_count<H_TOTAL-1 → +1; else → 0.
  - enable_v = pix_tick & (h_count==H_TOTAL-1).
- Vertical counter: advances only on enable_v, with the same wrap rule at V_TOTAL-1.
- Phase FSM, one per axis, using axis thresholds:
  - ACTIVE → FP when next count == ACTIVE
  - FP → SYNC at ACTIVE+FP
  - SYNC → BP at ACTIVE+FP+SYNC
  - BP → ACTIVE on wrap to 0
  - FSM state is illegal-state-safe: any unreachable encoding → ACTIVE at the next tick of that axis.
- Registered decode: hsync, vsync and video_on are registered and computed from the next count/state. They are therefore always consistent with the h_count/v_count visible in the same cycle (zero-cycle skew).
  - hsync=0 iff h_count ∈ [656,751] (defaults)
  - vsync=0 iff v_count ∈ [490,491]
  - video_on = (h_count<640)&(v_count<480)
- Strobes:
  - line_end: registered; high for exactly one clk, in the cycle after the edge where h_count wrapped 799→0.
  - frame_start: high for one clk when both wrap on the same edge.
  - Neither strobe asserts at reset release.
- enable low: all registers hold and pix_tick=0; strobes drop to 0 after one cycle, are not re-issued, and are not lost. Resume continues from the frozen point.
- Reset mid-frame: next edge forces every reset value regardless of state or enable.
- Widths: counters are 10 bits; parameters must satisfy H_TOTAL, V_TOTAL ≤ 1024 (elaboration assertion).

Decomposition:
- Package vga_timing_pkg:
  - phase_t enum {ACTIVE, FP, SYNC, BP}
  - default timing constants
  - derived H_TOTAL/V_TOTAL and sync start/end functions
- One sub-module, vga_axis_seq (count + phase FSM + wrap pulse, params ACTIVE/FP/SYNC/BP), instantiated for h (step=pix_tick) and v (step=enable_v).

Test Plan:
- Reset release, enable=1 → pix_tick first high at clk cycle 3, then every 4th cycle. h_count=1 after the first tick; v_count stays 0 until the 800th tick.
- Run one line → hsync falls on the 656th tick edge and rises on the 752nd. line_end pulses once, 3200 clks per line. video_on falls at h_count=640.
- Run one frame (800×525×4 = 1,680,000 clks) → vsync low exactly for v_count 490–491 (1600 ticks). frame_start pulses exactly once, at (0,0).
- Drop enable for 37 cycles at h_count=799, div_cnt=2 → all outputs frozen, no wrap. After re-enable, the wrap and line_end occur 1 clk later.
- Assert rst_n=0 for 1 cycle at (700,491) with vsync=0 → next edge gives (0,0), hsync=vsync=1, video_on=1, no frame_start.
- CLK_DIV=1, H_ACTIVE=8, H_FP=H_SYNC=H_BP=2, V_ACTIVE=4, V_FP=V_SYNC=V_BP=1 → 14-clk lines, 7-line frame. hsync low at h_count 10–11; vsync low at v_count 5.
